// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with a registered one-hot grant that is held until the owner drops its
// request. Optional hold watchdog is compiled in with `define ARB_TIMEOUT_EN.
module rr_arbiter_fsm #(
    parameter int unsigned N        = 3,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e        state_q;
    logic [N-1:0]  gnt_q;
    logic          gnt_valid_q;
    logic [IW-1:0] gnt_id_q;
    logic [IW-1:0] ptr_q;

    // Arbitration result, meaningful only while idle
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_rot;
    logic           pick_found;
    logic [IW-1:0]  pick_id;
    logic [N-1:0]   pick_onehot;
    logic [IW-1:0]  ptr_next;

    // Rotate req so that bit k is requester (ptr + k) mod N, then take the lowest set bit.
    always_comb begin
        req_dbl    = {req, req};
        req_rot    = req_dbl >> ptr_q;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            logic [IW:0] sum;
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!pick_found && req_rot[k]) begin
                pick_found = 1'b1;
                pick_id    = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pick_onehot[i] = pick_found && (pick_id == IW'(i));
        end
        ptr_next = (pick_id == IW'(N - 1)) ? '0 : pick_id + IW'(1);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HoldLimit = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt_q;
    logic          timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q     <= StGrant;
                        gnt_q       <= pick_onehot;
                        gnt_valid_q <= 1'b1;
                        gnt_id_q    <= pick_id;
                        ptr_q       <= ptr_next;
                        hold_cnt_q  <= '0;
                    end
                end
                StGrant: begin
                    // Voluntary release wins over the watchdog on the same edge
                    if (!req[gnt_id_q]) begin
                        state_q     <= StIdle;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end else if (hold_cnt_q == HoldLimit) begin
                        state_q     <= StIdle;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign timeout = timeout_q;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q     <= StGrant;
                        gnt_q       <= pick_onehot;
                        gnt_valid_q <= 1'b1;
                        gnt_id_q    <= pick_id;
                        ptr_q       <= ptr_next;
                    end
                end
                StGrant: begin
                    if (!req[gnt_id_q]) begin
                        state_q     <= StIdle;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

    a_params: assert property (@(posedge clk) (N >= 2) && (N <= 8) && (MAX_HOLD >= 2));
    a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_q));
    a_valid: assert property (@(posedge clk) disable iff (!reset_n) gnt_valid_q == (|gnt_q));
    a_id_match: assert property (@(posedge clk) disable iff (!reset_n)
                                 !gnt_valid_q || gnt_q[gnt_id_q]);
    a_ptr_range: assert property (@(posedge clk) disable iff (!reset_n) ptr_q <= IW'(N - 1));

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm with N=3; timeout scenarios run when ARB_TIMEOUT_EN is set.
module tb_rr_arbiter_fsm;

    localparam int unsigned N        = 3;
    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;
    logic [6:0] obs;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rr_arbiter_fsm #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // {gnt, gnt_valid, gnt_id, timeout}
    assign obs = {gnt, gnt_valid, gnt_id, timeout};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = 3'b000;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if (obs !== 7'b000_0_00_0) $display("FAIL reset_state: got %b want %b", obs, 7'b000_0_00_0);
        else pass_cnt++;

        req = 3'b010;
        tick();
        total_cnt++;
        if (obs !== 7'b010_1_01_0) $display("FAIL grant_010: got %b want %b", obs, 7'b010_1_01_0);
        else pass_cnt++;

        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 7'b000_0_00_0) $display("FAIL async_reset: got %b want %b", obs, 7'b000_0_00_0);
        else pass_cnt++;

        #1;
        reset_n = 1'b1;
        req = 3'b111;
        tick();
        total_cnt++;
        if (obs !== 7'b001_1_00_0) $display("FAIL post_reset_first: got %b want %b", obs, 7'b001_1_00_0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] rq    [10];
        logic [2:0] exp_g [10];
        logic [1:0] exp_i [10];
        logic [6:0] exp_v;
        rq    = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b101, 3'b111, 3'b111, 3'b011, 3'b111};
        exp_g = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
        exp_i = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            req = rq[k];
            tick();
            exp_v = {exp_g[k], |exp_g[k], exp_i[k], 1'b0};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL back_to_back[%0d]: got %b want %b", k, obs, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int hold_cycles;
`ifdef ARB_TIMEOUT_EN
        hold_cycles = MAX_HOLD - 1;
`else
        hold_cycles = 100;
`endif
        apply_reset();
        req = 3'b100;
        tick();
        total_cnt++;
        if (obs !== 7'b100_1_10_0) $display("FAIL hold_first: got %b want %b", obs, 7'b100_1_10_0);
        else pass_cnt++;
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            total_cnt++;
            if (obs !== 7'b100_1_10_0) $display("FAIL hold[%0d]: got %b want %b", i, obs, 7'b100_1_10_0);
            else pass_cnt++;
        end
        req = 3'b000;
        tick();
        total_cnt++;
        if (obs !== 7'b000_0_10_0) $display("FAIL hold_release: got %b want %b", obs, 7'b000_0_10_0);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [2:0] rq    [5];
        logic [6:0] exp_v [5];
        rq    = '{3'b010, 3'b000, 3'b101, 3'b001, 3'b001};
        exp_v = '{7'b010_1_01_0, 7'b000_0_01_0, 7'b100_1_10_0, 7'b000_0_10_0, 7'b001_1_00_0};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            req = rq[k];
            tick();
            total_cnt++;
            if (obs !== exp_v[k]) $display("FAIL wrap[%0d]: got %b want %b", k, obs, exp_v[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_no_preempt();
        logic [2:0] rq    [5];
        logic [6:0] exp_v [5];
        rq    = '{3'b100, 3'b101, 3'b101, 3'b001, 3'b001};
        exp_v = '{7'b100_1_10_0, 7'b100_1_10_0, 7'b100_1_10_0, 7'b000_0_10_0, 7'b001_1_00_0};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            req = rq[k];
            tick();
            total_cnt++;
            if (obs !== exp_v[k]) $display("FAIL no_preempt[%0d]: got %b want %b", k, obs, exp_v[k]);
            else pass_cnt++;
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        req = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (obs !== 7'b001_1_00_0) $display("FAIL to_hold[%0d]: got %b want %b", i, obs, 7'b001_1_00_0);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (obs !== 7'b000_0_00_1) $display("FAIL to_pulse: got %b want %b", obs, 7'b000_0_00_1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (obs !== 7'b001_1_00_0) $display("FAIL to_regrant: got %b want %b", obs, 7'b001_1_00_0);
        else pass_cnt++;

        apply_reset();
        req = 3'b001;
        for (int i = 0; i < 4; i++) tick();
        req = 3'b000;
        tick();
        total_cnt++;
        if (obs !== 7'b000_0_00_0) $display("FAIL to_voluntary: got %b want %b", obs, 7'b000_0_00_0);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_wrap();
        test_no_preempt();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
